multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 240 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: FSM controller for a multicycle processor datapath.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, drives the
// datapath strobes, tracks memory-acknowledge waits with a timeout, and
// counts retired instructions.
//
// Ports
//   clock, reset       : clock and synchronous active-high reset
//   op                 : instruction-register opcode, captured in DECODE
//   imem_ack, dmem_ack : instruction / data memory acknowledges
//   cond               : branch condition from the ALU (used in EXEC)
//   imem_req, dmem_req : memory request strobes
//   dmwe               : data-memory write enable
//   pc_we, ir_we       : PC / instruction-register write enables
//   pc_sel             : 00 PC+1, 01 branch, 10 jump imm, 11 register
//   rwe, rdst, aluinb  : register write, port-B reads rd, ALU B is immediate
//   rwd, rlink         : write data from memory, write PC+1 to r31
//   illegal, timeout   : sticky error flags
//   state              : current FSM state (FETCH=0 .. ERR=5)
//   retired            : completed-instruction counter (wraps)
module multicycle_control #(
   parameter int unsigned OP_W    = 5,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned RET_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [OP_W-1:0]  op,
   input  logic             imem_ack,
   input  logic             dmem_ack,
   input  logic             cond,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmwe,
   output logic             pc_we,
   output logic             ir_we,
   output logic [1:0]       pc_sel,
   output logic             rwe,
   output logic             rdst,
   output logic             aluinb,
   output logic             rwd,
   output logic             rlink,
   output logic             illegal,
   output logic             timeout,
   output logic [2:0]       state,
   output logic [RET_W-1:0] retired
);

   // Wait counter only has to reach TIMEOUT-1 before the FSM gives up.
   localparam int unsigned WAIT_W = $clog2(TIMEOUT);

   localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
   localparam logic [OP_W-1:0] OP_J    = OP_W'(1);
   localparam logic [OP_W-1:0] OP_BNE  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_JAL  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_JR   = OP_W'(4);
   localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5);
   localparam logic [OP_W-1:0] OP_BLT  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_SW   = OP_W'(7);
   localparam logic [OP_W-1:0] OP_LW   = OP_W'(8);

   localparam logic [1:0] PC_INC = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;
   localparam logic [1:0] PC_REG = 2'b11;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [OP_W-1:0]    op_q;
   logic [WAIT_W-1:0]  wait_q;
   logic [RET_W-1:0]   retired_q;
   logic               illegal_q, timeout_q;
   logic               illegal_set, timeout_set;
   logic               wait_max;
   logic               in_instr;
   logic               retire;

   function automatic logic op_legal(input logic [OP_W-1:0] o);
      logic ok;
      ok = 1'b0;
      case (o)
         OP_R, OP_J, OP_BNE, OP_JAL, OP_JR,
         OP_ADDI, OP_BLT, OP_SW, OP_LW: ok = 1'b1;
         default:                       ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign wait_max = (wait_q == WAIT_W'(TIMEOUT - 1));

   // Phases after DECODE in which op_q describes the current instruction.
   assign in_instr = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

   // An instruction retires whenever one of its late phases hands back to FETCH.
   assign retire = in_instr && (state_d == S_FETCH);

   // Next-state and strobe decode.
   always_comb begin
      state_d     = state_q;
      illegal_set = 1'b0;
      timeout_set = 1'b0;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmwe        = 1'b0;
      pc_we       = 1'b0;
      ir_we       = 1'b0;
      pc_sel      = PC_INC;
      rwe         = 1'b0;
      rwd         = 1'b0;
      rlink       = 1'b0;

      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               pc_sel  = PC_INC;
               state_d = S_DECODE;
            end else if (wait_max) begin
               timeout_set = 1'b1;
               state_d     = S_ERR;
            end
         end

         S_DECODE: begin
            if (op_legal(op)) begin
               state_d = S_EXEC;
            end else begin
               illegal_set = 1'b1;
               state_d     = S_ERR;
            end
         end

         S_EXEC: begin
            case (op_q)
               OP_R, OP_ADDI, OP_JAL: state_d = S_WB;
               OP_LW, OP_SW:          state_d = S_MEM;
               OP_J: begin
                  pc_we   = 1'b1;
                  pc_sel  = PC_JMP;
                  state_d = S_FETCH;
               end
               OP_JR: begin
                  pc_we   = 1'b1;
                  pc_sel  = PC_REG;
                  state_d = S_FETCH;
               end
               OP_BNE, OP_BLT: begin
                  pc_we   = cond;
                  pc_sel  = PC_BR;
                  state_d = S_FETCH;
               end
               default: state_d = S_ERR;
            endcase
         end

         S_MEM: begin
            dmem_req = 1'b1;
            dmwe     = (op_q == OP_SW);
            if (dmem_ack) begin
               state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
            end else if (wait_max) begin
               timeout_set = 1'b1;
               state_d     = S_ERR;
            end
         end

         S_WB: begin
            rwe = 1'b1;
            rwd = (op_q == OP_LW);
            if (op_q == OP_JAL) begin
               rlink  = 1'b1;
               pc_we  = 1'b1;
               pc_sel = PC_JMP;
            end
            state_d = S_FETCH;
         end

         S_ERR: state_d = S_ERR;

         default: state_d = S_ERR;
      endcase
   end

   // Operand-select lines held for the whole of the instruction after DECODE.
   always_comb begin
      aluinb = 1'b0;
      rdst   = 1'b0;
      if (in_instr) begin
         aluinb = (op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW);
         rdst   = (op_q == OP_SW) || (op_q == OP_BNE) || (op_q == OP_BLT) || (op_q == OP_JR);
      end
   end

   // State register, opcode capture, wait counter, retire counter and flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         wait_q    <= '0;
         retired_q <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            op_q <= op;
         end
         // Staying in FETCH/MEM implies the ack has not arrived yet.
         if (state_d != state_q) begin
            wait_q <= '0;
         end else if ((state_q == S_FETCH) || (state_q == S_MEM)) begin
            wait_q <= wait_q + WAIT_W'(1);
         end
         if (retire) begin
            retired_q <= retired_q + RET_W'(1);
         end
         if (illegal_set) begin
            illegal_q <= 1'b1;
         end
         if (timeout_set) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign state   = state_q;
   assign retired = retired_q;
   assign illegal = illegal_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (TIMEOUT=4, RET_W=2).
// The stimulus process drives one cycle at a time and queues the expected
// outputs for that cycle; the monitor pops and compares on the falling edge.
module tb_multicycle_control;

   localparam int unsigned OP_W  = 5;
   localparam int unsigned RET_W = 2;

   logic             clock = 1'b0;
   logic             reset;
   logic [OP_W-1:0]  op;
   logic             imem_ack, dmem_ack, cond;
   logic             imem_req, dmem_req, dmwe, pc_we, ir_we;
   logic [1:0]       pc_sel;
   logic             rwe, rdst, aluinb, rwd, rlink;
   logic             illegal, timeout;
   logic [2:0]       state;
   logic [RET_W-1:0] retired;

   multicycle_control #(.OP_W(OP_W), .TIMEOUT(4), .RET_W(RET_W)) dut (
      .clock    (clock),
      .reset    (reset),
      .op       (op),
      .imem_ack (imem_ack),
      .dmem_ack (dmem_ack),
      .cond     (cond),
      .imem_req (imem_req),
      .dmem_req (dmem_req),
      .dmwe     (dmwe),
      .pc_we    (pc_we),
      .ir_we    (ir_we),
      .pc_sel   (pc_sel),
      .rwe      (rwe),
      .rdst     (rdst),
      .aluinb   (aluinb),
      .rwd      (rwd),
      .rlink    (rlink),
      .illegal  (illegal),
      .timeout  (timeout),
      .state    (state),
      .retired  (retired)
   );

   always #5 clock = ~clock;

   // Strobe field order: {imem_req,dmem_req,dmwe,pc_we,ir_we,pc_sel,rwe,rdst,aluinb,rwd,rlink}
   localparam logic [11:0] NONE = 12'b0;
   localparam logic [11:0] FW   = 12'b1_0_0_0_0_00_0_0_0_0_0;
   localparam logic [11:0] FA   = 12'b1_0_0_1_1_00_0_0_0_0_0;
   localparam logic [4:0]  JUNK = 5'b11111;

   // {state, strobes, illegal, timeout, retired}
   logic [18:0] exp_q[$];
   string       nm_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   logic [18:0] act;
   assign act = {state, imem_req, dmem_req, dmwe, pc_we, ir_we, pc_sel,
                 rwe, rdst, aluinb, rwd, rlink, illegal, timeout, retired};

   // Monitor: one expected record per driven cycle.
   always @(negedge clock) begin
      logic [18:0] e;
      string       n;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n = nm_q.pop_front();
         vectors++;
         if (act !== e) begin
            miscompares++;
            $display("FAIL %s: got st=%0d strb=%b ill=%b to=%b ret=%0d, expected st=%0d strb=%b ill=%b to=%b ret=%0d",
                     n, act[18:16], act[15:4], act[3], act[2], act[1:0],
                     e[18:16], e[15:4], e[3], e[2], e[1:0]);
         end
      end
   end

   task automatic cyc(input string nm, input logic ia, input logic da, input logic c,
                      input logic [4:0] o, input logic [2:0] st, input logic [11:0] sb,
                      input logic ill, input logic to, input logic [1:0] ret);
      imem_ack = ia;
      dmem_ack = da;
      cond     = c;
      op       = o;
      exp_q.push_back({st, sb, ill, to, ret});
      nm_q.push_back(nm);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      cond     = 1'b0;
      op       = JUNK;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      do_reset();

      // addi with imem_ack on the third FETCH cycle, then lw with a 3-cycle MEM
      cyc("addi_f0",     0,0,0,JUNK,    3'd0,FW,0,0,2'd0);
      cyc("addi_f1",     0,0,0,JUNK,    3'd0,FW,0,0,2'd0);
      cyc("addi_f2",     1,0,0,JUNK,    3'd0,FA,0,0,2'd0);
      cyc("addi_dec",    0,0,1,5'b00101,3'd1,NONE,0,0,2'd0);
      cyc("addi_exec",   0,0,1,JUNK,    3'd2,12'b0_0_0_0_0_00_0_0_1_0_0,0,0,2'd0);
      cyc("addi_wb",     0,0,0,JUNK,    3'd4,12'b0_0_0_0_0_00_1_0_1_0_0,0,0,2'd0);
      cyc("lw_fetch",    1,0,0,JUNK,    3'd0,FA,0,0,2'd1);
      cyc("lw_dec",      0,0,0,5'b01000,3'd1,NONE,0,0,2'd1);
      cyc("lw_exec",     0,1,0,JUNK,    3'd2,12'b0_0_0_0_0_00_0_0_1_0_0,0,0,2'd1);
      cyc("lw_mem0",     0,0,0,JUNK,    3'd3,12'b0_1_0_0_0_00_0_0_1_0_0,0,0,2'd1);
      cyc("lw_mem1",     0,0,0,JUNK,    3'd3,12'b0_1_0_0_0_00_0_0_1_0_0,0,0,2'd1);
      cyc("lw_mem2",     0,1,0,JUNK,    3'd3,12'b0_1_0_0_0_00_0_0_1_0_0,0,0,2'd1);
      cyc("lw_wb",       0,0,0,JUNK,    3'd4,12'b0_0_0_0_0_00_1_0_1_1_0,0,0,2'd1);
      cyc("lw_after",    0,0,0,JUNK,    3'd0,FW,0,0,2'd2);

      // sw, bne not taken, blt taken, j, jr, jal
      do_reset();
      cyc("sw_fetch",    1,0,0,JUNK,    3'd0,FA,0,0,2'd0);
      cyc("sw_dec",      0,0,0,5'b00111,3'd1,NONE,0,0,2'd0);
      cyc("sw_exec",     0,0,1,JUNK,    3'd2,12'b0_0_0_0_0_00_0_1_1_0_0,0,0,2'd0);
      cyc("sw_mem",      0,1,0,JUNK,    3'd3,12'b0_1_1_0_0_00_0_1_1_0_0,0,0,2'd0);
      cyc("bne_fetch",   1,0,0,JUNK,    3'd0,FA,0,0,2'd1);
      cyc("bne_dec",     0,0,1,5'b00010,3'd1,NONE,0,0,2'd1);
      cyc("bne_exec_nt", 0,0,0,JUNK,    3'd2,12'b0_0_0_0_0_01_0_1_0_0_0,0,0,2'd1);
      cyc("blt_fetch",   1,0,0,JUNK,    3'd0,FA,0,0,2'd2);
      cyc("blt_dec",     0,0,0,5'b00110,3'd1,NONE,0,0,2'd2);
      cyc("blt_exec_t",  0,0,1,JUNK,    3'd2,12'b0_0_0_1_0_01_0_1_0_0_0,0,0,2'd2);
      cyc("j_fetch",     1,0,0,JUNK,    3'd0,FA,0,0,2'd3);
      cyc("j_dec",       0,0,0,5'b00001,3'd1,NONE,0,0,2'd3);
      cyc("j_exec",      0,0,1,JUNK,    3'd2,12'b0_0_0_1_0_10_0_0_0_0_0,0,0,2'd3);
      cyc("jr_fetch",    1,0,0,JUNK,    3'd0,FA,0,0,2'd0);
      cyc("jr_dec",      0,0,0,5'b00100,3'd1,NONE,0,0,2'd0);
      cyc("jr_exec",     0,0,0,JUNK,    3'd2,12'b0_0_0_1_0_11_0_1_0_0_0,0,0,2'd0);
      cyc("jal_fetch",   1,0,0,JUNK,    3'd0,FA,0,0,2'd1);
      cyc("jal_dec",     0,0,0,5'b00011,3'd1,NONE,0,0,2'd1);
      cyc("jal_exec",    0,0,1,JUNK,    3'd2,NONE,0,0,2'd1);
      cyc("jal_wb",      0,0,0,JUNK,    3'd4,12'b0_0_0_1_0_10_1_0_0_0_1,0,0,2'd1);
      cyc("jal_after",   0,0,0,JUNK,    3'd0,FW,0,0,2'd2);

      // five R-type instructions: retired wraps 1,2,3,0,1
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cyc("r_fetch",  1,0,0,JUNK,    3'd0,FA,0,0,2'(i));
         cyc("r_dec",    0,0,0,5'b00000,3'd1,NONE,0,0,2'(i));
         cyc("r_exec",   0,0,0,JUNK,    3'd2,NONE,0,0,2'(i));
         cyc("r_wb",     0,0,0,JUNK,    3'd4,12'b0_0_0_0_0_00_1_0_0_0_0,0,0,2'(i));
      end
      cyc("r_wrap_end",  0,0,0,JUNK,    3'd0,FW,0,0,2'd1);

      // illegal opcode: ERR is sticky for 20 cycles despite acks, reset clears
      do_reset();
      cyc("ill_r_fetch", 1,0,0,JUNK,    3'd0,FA,0,0,2'd0);
      cyc("ill_r_dec",   0,0,0,5'b00000,3'd1,NONE,0,0,2'd0);
      cyc("ill_r_exec",  0,0,0,JUNK,    3'd2,NONE,0,0,2'd0);
      cyc("ill_r_wb",    0,0,0,JUNK,    3'd4,12'b0_0_0_0_0_00_1_0_0_0_0,0,0,2'd0);
      cyc("ill_fetch",   1,0,0,JUNK,    3'd0,FA,0,0,2'd1);
      cyc("ill_dec",     0,0,0,5'b11111,3'd1,NONE,0,0,2'd1);
      for (int i = 0; i < 20; i++) begin
         cyc("ill_err",  1,1,1,5'b00000,3'd5,NONE,1,0,2'd1);
      end
      do_reset();
      cyc("ill_reset",   0,0,0,JUNK,    3'd0,FW,0,0,2'd0);

      // imem timeout after 4 FETCH cycles
      cyc("to_f1",       0,0,0,JUNK,    3'd0,FW,0,0,2'd0);
      cyc("to_f2",       0,0,0,JUNK,    3'd0,FW,0,0,2'd0);
      cyc("to_f3",       0,0,0,JUNK,    3'd0,FW,0,0,2'd0);
      for (int i = 0; i < 3; i++) begin
         cyc("to_err",   1,1,0,JUNK,    3'd5,NONE,0,1,2'd0);
      end

      // ack on the 4th FETCH cycle wins; then a dmem timeout in MEM
      do_reset();
      cyc("ack4_f0",     0,0,0,JUNK,    3'd0,FW,0,0,2'd0);
      cyc("ack4_f1",     0,0,0,JUNK,    3'd0,FW,0,0,2'd0);
      cyc("ack4_f2",     0,0,0,JUNK,    3'd0,FW,0,0,2'd0);
      cyc("ack4_f3",     1,0,0,JUNK,    3'd0,FA,0,0,2'd0);
      cyc("ack4_dec",    0,0,0,5'b01000,3'd1,NONE,0,0,2'd0);
      cyc("mto_exec",    0,0,0,JUNK,    3'd2,12'b0_0_0_0_0_00_0_0_1_0_0,0,0,2'd0);
      for (int i = 0; i < 4; i++) begin
         cyc("mto_mem",  0,0,0,JUNK,    3'd3,12'b0_1_0_0_0_00_0_0_1_0_0,0,0,2'd0);
      end
      cyc("mto_err",     0,1,0,JUNK,    3'd5,NONE,0,1,2'd0);

      // reset in the middle of a data-memory handshake
      do_reset();
      cyc("mid_fetch",   1,0,0,JUNK,    3'd0,FA,0,0,2'd0);
      cyc("mid_dec",     0,0,0,5'b00111,3'd1,NONE,0,0,2'd0);
      cyc("mid_exec",    0,0,0,JUNK,    3'd2,12'b0_0_0_0_0_00_0_1_1_0_0,0,0,2'd0);
      cyc("mid_mem",     0,0,0,JUNK,    3'd3,12'b0_1_1_0_0_00_0_1_1_0_0,0,0,2'd0);
      do_reset();
      cyc("mid_reset",   0,0,0,JUNK,    3'd0,FW,0,0,2'd0);

      // let the monitor drain, bounded
      for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
         @(posedge clock);
      end
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending records, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
